// File: rtl/load_store_unit.sv
// load_store_unit
//   Moves one RV32I load or store between the core and a ready/valid data
//   memory. A request is latched in IDLE, checked for legality (funct3 and
//   alignment), then issued in REQUEST until mem_ready or the timeout, and
//   reported with a one-cycle DONE.
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   lsu_start, lsu_store         request strobe (IDLE only), 1=store 0=load
//   funct3, lsu_address, rs2     access size/sign, byte address, store data
//   lsu_busy, lsu_done           not-IDLE flag, one-cycle completion pulse
//   lsu_error                    qualifies lsu_done: illegal, misaligned, timeout
//   load_value                   extended result of the last successful load
//   mem_req, mem_we, mem_address, mem_byte_en, mem_wdata   memory request
//   mem_rdata, mem_ready         memory response
module load_store_unit #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        lsu_start,
  input  logic        lsu_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] lsu_address,
  input  logic [31:0] rs2,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic        lsu_error,
  output logic [31:0] load_value,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_byte_en,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQUEST, DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_store;
  logic [2:0]        r_funct3;
  logic [31:0]       r_addr;
  logic [31:0]       r_rs2;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_load_value;
  logic              w_legal;
  logic              w_hs;
  logic              w_timeout;

  // funct3 legality plus natural alignment of the access
  function automatic logic is_legal(input logic st, input logic [2:0] f3,
                                    input logic [1:0] a);
    logic ok;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~a[0];
      3'b010:  ok = (a == 2'b00);
      3'b100:  ok = ~st;
      3'b101:  ok = ~st & ~a[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] be;
    case (sz)
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = 4'b0011 << {a[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data is replicated across lanes so byte_en alone selects the target
  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] wd;
    case (sz)
      2'b00:   wd = {4{d[7:0]}};
      2'b01:   wd = {2{d[15:0]}};
      default: wd = d;
    endcase
    return wd;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] d);
    logic [31:0] sh;
    logic [31:0] v;
    sh = d >> {a, 3'b000};
    case (f3)
      3'b000:  v = {{24{sh[7]}}, sh[7:0]};
      3'b001:  v = {{16{sh[15]}}, sh[15:0]};
      3'b100:  v = {24'b0, sh[7:0]};
      3'b101:  v = {16'b0, sh[15:0]};
      default: v = d;
    endcase
    return v;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_hs        = 1'b0;
    w_timeout   = 1'b0;
    w_legal     = is_legal(lsu_store, funct3, lsu_address[1:0]);
    case (r_state)
      IDLE: begin
        if (lsu_start) w_state_nxt = w_legal ? REQUEST : DONE;
      end
      REQUEST: begin
        // a handshake on the final allowed cycle wins over the timeout
        w_hs      = mem_ready;
        w_timeout = ~mem_ready && (r_cnt == CNT_LAST);
        if (w_hs || w_timeout) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_load_value <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (lsu_start) begin
            r_err <= ~w_legal;
            r_cnt <= '0;
          end
        end
        REQUEST: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_hs) begin
            r_err <= 1'b0;
            if (!r_store) r_load_value <= load_extract(r_funct3, r_addr[1:0], mem_rdata);
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Request fields: captured once in IDLE, stable for the whole access
  always_ff @(posedge clk) begin
    if (r_state == IDLE && lsu_start) begin
      r_store  <= lsu_store;
      r_funct3 <= funct3;
      r_addr   <= lsu_address;
      r_rs2    <= rs2;
    end
  end

  assign lsu_busy    = (r_state != IDLE);
  assign lsu_done    = (r_state == DONE);
  assign lsu_error   = lsu_done & r_err;
  assign mem_req     = (r_state == REQUEST);
  assign mem_we      = mem_req & r_store;
  assign mem_address = mem_req ? {r_addr[31:2], 2'b00} : '0;
  assign mem_byte_en = mem_req ? byte_en(r_funct3[1:0], r_addr[1:0]) : '0;
  assign mem_wdata   = (mem_req & r_store) ? store_data(r_funct3[1:0], r_rs2) : '0;
  assign load_value  = r_load_value;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Directed transactions against load_store_unit. A transaction-level model
//   (legality, lane mask, replicated data, extracted load value) sets the
//   expected outputs for every cycle; one process compares them on the
//   falling edge. Literal expectations pin the model and the key scenarios.
module tb_load_store_unit;

  localparam int T = 15;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        lsu_start;
  logic        lsu_store;
  logic [2:0]  funct3;
  logic [31:0] lsu_address;
  logic [31:0] rs2;
  logic        lsu_busy;
  logic        lsu_done;
  logic        lsu_error;
  logic [31:0] load_value;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_address;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int total = 0;
  int bad   = 0;

  logic        chk_en = 1'b0;
  logic        e_busy, e_done, e_err, e_req, e_we, e_memchk, e_wdchk, e_errchk;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_be;
  logic [31:0] m_lv;

  logic        cap_req_seen, cap_we, cap_done, cap_err;
  logic [3:0]  cap_be;
  logic [31:0] cap_addr, cap_wdata;
  int          cap_lat;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .reset_n(reset_n), .lsu_start(lsu_start), .lsu_store(lsu_store),
    .funct3(funct3), .lsu_address(lsu_address), .rs2(rs2),
    .lsu_busy(lsu_busy), .lsu_done(lsu_done), .lsu_error(lsu_error),
    .load_value(load_value), .mem_req(mem_req), .mem_we(mem_we),
    .mem_address(mem_address), .mem_byte_en(mem_byte_en), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    total++;
    if (act !== ex) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, ex, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic int m_size(input logic [2:0] f3);
    case (f3 % 4)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit m_legal(input logic st, input logic [2:0] f3, input logic [31:0] a);
    bit fok;
    if (st) fok = f3 inside {3'd0, 3'd1, 3'd2};
    else    fok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    return fok && ((a % m_size(f3)) == 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] be = '0;
    int off = int'(a % 4);
    int sz  = m_size(f3);
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + sz) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] wd = '0;
    int sz = m_size(f3);
    for (int i = 0; i < 4; i++) wd[8*i +: 8] = d[8*(i % sz) +: 8];
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] d);
    longint v;
    int sz = m_size(f3);
    int nb = 8 * sz;
    v = longint'(d) >> (8 * int'(a % 4));
    v = v & ((64'sd1 << nb) - 1);
    if (f3[2] == 1'b0 && sz < 4 && v >= (64'sd1 << (nb - 1))) v = v - (64'sd1 << nb);
    return 32'(v);
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(lsu_busy), 32'(e_busy));
      chk("done", 32'(lsu_done), 32'(e_done));
      if (e_errchk) chk("error", 32'(lsu_error), 32'(e_err));
      chk("mem_req", 32'(mem_req), 32'(e_req));
      chk("load_value", load_value, m_lv);
      if (e_memchk) begin
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_address", mem_address, e_addr);
        chk("mem_byte_en", 32'(mem_byte_en), 32'(e_be));
        if (e_wdchk) chk("mem_wdata", mem_wdata, e_wdata);
      end
    end
  end

  task automatic set_idle();
    e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_errchk = 1'b1; e_req = 1'b0;
    e_memchk = 1'b1; e_wdchk = 1'b1; e_we = 1'b0; e_addr = '0; e_be = '0; e_wdata = '0;
  endtask

  task automatic garbage_inputs(input logic st);
    lsu_start = 1'b1; lsu_store = ~st; funct3 = 3'b111;
    lsu_address = 32'hDEADBEEF; rs2 = 32'h5A5A5A5A;
  endtask

  // delay: index of the REQUEST cycle carrying mem_ready, or -1 for never
  task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] rdata, input int delay);
    bit hs = 1'b0;
    int k = 0;
    cap_req_seen = 1'b0; cap_lat = 0; cap_done = 1'b0; cap_err = 1'b0;
    cap_be = '0; cap_addr = '0; cap_wdata = '0; cap_we = 1'b0;
    // start cycle, stray mem_ready must be ignored
    lsu_start = 1'b1; lsu_store = st; funct3 = f3; lsu_address = a; rs2 = d;
    mem_rdata = rdata; mem_ready = 1'b1;
    set_idle();
    if (mem_req) cap_req_seen = 1'b1;
    @(posedge clk); #1;
    garbage_inputs(st);
    if (m_legal(st, f3, a)) begin
      forever begin
        cap_lat++;
        mem_ready = (k == delay);
        e_busy = 1'b1; e_done = 1'b0; e_err = 1'b0; e_req = 1'b1; e_memchk = 1'b1;
        e_we = st; e_addr = a & ~32'd3; e_be = m_be(f3, a);
        e_wdchk = st; e_wdata = m_wdata(f3, d);
        if (mem_req) begin
          cap_req_seen = 1'b1; cap_be = mem_byte_en; cap_addr = mem_address;
          cap_wdata = mem_wdata; cap_we = mem_we;
        end
        @(posedge clk); #1;
        if (k == delay) begin hs = 1'b1; break; end
        if (k == T - 1) break;
        k++;
      end
      e_err = ~hs;
      if (hs && !st) m_lv = m_load(f3, a, rdata);
    end else begin
      e_err = 1'b1;
    end
    // done cycle
    cap_lat++;
    mem_ready = 1'b1;
    e_busy = 1'b1; e_done = 1'b1; e_errchk = 1'b1; e_req = 1'b0; e_memchk = 1'b0;
    if (mem_req) cap_req_seen = 1'b1;
    cap_done = lsu_done; cap_err = lsu_error;
    @(posedge clk); #1;
    lsu_start = 1'b0; mem_ready = 1'b0;
    set_idle();
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0; lsu_start = 1'b0; lsu_store = 1'b0; funct3 = '0;
    lsu_address = '0; rs2 = '0; mem_rdata = '0; mem_ready = 1'b0;
    m_lv = '0;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("rst_load_value", load_value, 32'h0);
    chk("rst_busy", 32'(lsu_busy), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk_en = 1'b1;

    // model pins
    chk("model_lb", m_load(3'b000, 32'h1003, 32'h80FFFFFF), 32'hFFFFFF80);
    chk("model_lh", m_load(3'b001, 32'h0012, 32'h9ABC1234), 32'hFFFF9ABC);
    chk("model_sh_wd", m_wdata(3'b001, 32'h1234ABCD), 32'hABCDABCD);
    chk("model_sh_be", 32'(m_be(3'b001, 32'h2002)), 32'h0000000C);

    // LB, immediate ready
    txn(1'b0, 3'b000, 32'h00001003, 32'h0, 32'h80FFFFFF, 0);
    chk("lb_be", 32'(cap_be), 32'h8);
    chk("lb_addr", cap_addr, 32'h00001000);
    chk("lb_value", load_value, 32'hFFFFFF80);
    chk("lb_latency", cap_lat, 2);
    chk("lb_err", 32'(cap_err), 32'h0);

    // SH
    txn(1'b1, 3'b001, 32'h00002002, 32'h1234ABCD, 32'h0, 0);
    chk("sh_we", 32'(cap_we), 32'h1);
    chk("sh_be", 32'(cap_be), 32'hC);
    chk("sh_wdata", cap_wdata, 32'hABCDABCD);
    chk("sh_addr", cap_addr, 32'h00002000);
    chk("sh_keeps_lv", load_value, 32'hFFFFFF80);

    // misaligned LW
    txn(1'b0, 3'b010, 32'h00003001, 32'h0, 32'h11111111, 0);
    chk("lw_mis_latency", cap_lat, 1);
    chk("lw_mis_done", 32'(cap_done), 32'h1);
    chk("lw_mis_err", 32'(cap_err), 32'h1);
    chk("lw_mis_noreq", 32'(cap_req_seen), 32'h0);
    chk("lw_mis_keeps_lv", load_value, 32'hFFFFFF80);

    // LHU timeout, then LHU with ready on the third request cycle
    txn(1'b0, 3'b101, 32'h00004000, 32'h0, 32'h8765F00D, -1);
    chk("lhu_to_latency", cap_lat, T + 1);
    chk("lhu_to_err", 32'(cap_err), 32'h1);
    chk("lhu_to_keeps_lv", load_value, 32'hFFFFFF80);
    txn(1'b0, 3'b101, 32'h00004000, 32'h0, 32'h8765F00D, 2);
    chk("lhu_latency", cap_lat, 4);
    chk("lhu_err", 32'(cap_err), 32'h0);
    chk("lhu_value", load_value, 32'h0000F00D);

    // other sizes and lanes
    txn(1'b0, 3'b100, 32'h00000001, 32'h0, 32'h12AB34CD, 0);
    chk("lbu_value", load_value, 32'h00000034);
    txn(1'b0, 3'b001, 32'h00000012, 32'h0, 32'h9ABC1234, 1);
    chk("lh_value", load_value, 32'hFFFF9ABC);
    txn(1'b0, 3'b010, 32'h00000100, 32'h0, 32'hCAFEF00D, 1);
    chk("lw_value", load_value, 32'hCAFEF00D);
    txn(1'b1, 3'b000, 32'h00000007, 32'h000000A5, 32'h0, 0);
    chk("sb_be", 32'(cap_be), 32'h8);
    chk("sb_wdata", cap_wdata, 32'hA5A5A5A5);
    txn(1'b1, 3'b010, 32'h00000008, 32'h11223344, 32'h0, 4);
    chk("sw_be", 32'(cap_be), 32'hF);
    chk("sw_latency", cap_lat, 6);
    // store completing on the very last allowed cycle
    txn(1'b1, 3'b010, 32'h0000000C, 32'h55667788, 32'h0, T - 1);
    chk("sw_last_err", 32'(cap_err), 32'h0);

    // illegal encodings and misalignments
    txn(1'b0, 3'b011, 32'h00000000, 32'h0, 32'h0, 0);
    chk("ld_f3_011_err", 32'(cap_err), 32'h1);
    txn(1'b1, 3'b100, 32'h00000000, 32'h0, 32'h0, 0);
    chk("st_f3_100_err", 32'(cap_err), 32'h1);
    txn(1'b1, 3'b001, 32'h00000001, 32'h0, 32'h0, 0);
    chk("sh_mis_noreq", 32'(cap_req_seen), 32'h0);
    txn(1'b0, 3'b001, 32'h00000003, 32'h0, 32'h0, 0);
    chk("lh_mis_err", 32'(cap_err), 32'h1);
    chk("lh_mis_keeps_lv", load_value, 32'hCAFEF00D);

    // reset in the middle of a request
    lsu_start = 1'b1; lsu_store = 1'b0; funct3 = 3'b010; lsu_address = 32'h00005000;
    rs2 = '0; mem_rdata = 32'h77777777; mem_ready = 1'b0;
    set_idle();
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      garbage_inputs(1'b0);
      e_busy = 1'b1; e_req = 1'b1; e_memchk = 1'b1; e_we = 1'b0;
      e_addr = 32'h00005000; e_be = 4'hF; e_wdchk = 1'b0;
      if (i == 2) reset_n = 1'b0;
      @(posedge clk); #1;
    end
    reset_n = 1'b1; lsu_start = 1'b0; mem_ready = 1'b1;
    m_lv = '0;
    set_idle();
    chk("rstmid_mem_req", 32'(mem_req), 32'h0);
    chk("rstmid_busy", 32'(lsu_busy), 32'h0);
    chk("rstmid_lv", load_value, 32'h0);
    cap_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (lsu_done) cap_done = 1'b1;
      @(posedge clk); #1;
    end
    chk("rstmid_no_done", 32'(cap_done), 32'h0);
    mem_ready = 1'b0;

    // normal operation after the abort
    txn(1'b0, 3'b000, 32'h00000002, 32'h0, 32'h00420000, 0);
    chk("post_rst_lb", load_value, 32'h00000042);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
